boot_sequencer: RTL and testbench

BOOT_SEQUENCER -- requirements
Module: boot_sequencer

---
 rtl/cpu_pkg.sv | 18 +
 rtl/boot_sequencer.sv | 106 ++++++++++
 tb/tb_boot_sequencer.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared widths and boot sequencer state encoding
package cpu_pkg;

    localparam int ADDR_W  = 12;
    localparam int INSTR_W = 8;

    typedef logic [ADDR_W-1:0]  addr_t;
    typedef logic [INSTR_W-1:0] instr_t;

    localparam addr_t ADDR_MAX = '1;

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_HOLD = 2'd1,
        ST_RUN  = 2'd2
    } boot_state_t;

endpackage

// File: rtl/boot_sequencer.sv
// rtl/boot_sequencer.sv - loads a program into memory, holds the CPU in reset, then runs it
module boot_sequencer
    import cpu_pkg::*;
#(
    parameter int     RST_HOLD = 4,
    parameter instr_t NOP_CODE = 8'h00
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         ld_start,
    input  logic         ld_valid,
    input  logic [7:0]   ld_data,
    input  logic         ld_last,
    output logic         ld_ready,
    output logic         mem_we,
    output logic [11:0]  mem_addr,
    output logic [7:0]   mem_wdata,
    input  logic [7:0]   mem_rdata,
    input  logic [11:0]  cpu_address,
    output logic [7:0]   cpu_dbus,
    output logic         cpu_reset,
    output logic         busy,
    output logic         err_ovf
);

    localparam logic [7:0] HOLD_LAST = 8'(RST_HOLD - 1);

    boot_state_t state_q, state_d;
    addr_t       ptr_q, ptr_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        err_q, err_d;
    logic        cpu_reset_q;
    logic        xfer;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_HOLD;
            ptr_q       <= '0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            cpu_reset_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            cpu_reset_q <= (state_d != ST_RUN);
        end
    end

    // ld_start overrides everything, including a final-byte transfer in the same cycle
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        xfer    = (state_q == ST_LOAD) && ld_valid;
        if (ld_start) begin
            state_d = ST_LOAD;
            ptr_d   = '0;
            cnt_d   = '0;
            err_d   = 1'b0;
        end else begin
            case (state_q)
                ST_LOAD: begin
                    if (xfer) begin
                        if (ld_last) begin
                            state_d = ST_HOLD;
                            ptr_d   = '0;
                            cnt_d   = '0;
                        end else begin
                            ptr_d = ptr_q + 12'd1;
                            if (ptr_q == ADDR_MAX) err_d = 1'b1;
                        end
                    end
                end
                ST_HOLD: begin
                    if (cnt_q == HOLD_LAST) state_d = ST_RUN;
                    else                    cnt_d   = cnt_q + 8'd1;
                end
                ST_RUN:  ;
                default: state_d = ST_HOLD;
            endcase
        end
    end

    always_comb begin
        ld_ready  = (state_q == ST_LOAD);
        mem_we    = (state_q == ST_LOAD) && ld_valid;
        mem_wdata = ld_data;
        busy      = (state_q != ST_RUN);
        cpu_reset = cpu_reset_q;
        err_ovf   = err_q;
        cpu_dbus  = NOP_CODE;
        mem_addr  = '0;
        case (state_q)
            ST_LOAD: mem_addr = ptr_q;
            ST_RUN: begin
                mem_addr = cpu_address;
                cpu_dbus = mem_rdata;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_boot_sequencer.sv
// tb/tb_boot_sequencer.sv - self-checking bench for boot_sequencer
module tb_boot_sequencer;

    logic        clock = 1'b0;
    logic        reset;
    logic        ld_start, ld_valid, ld_last;
    logic [7:0]  ld_data;
    logic        ld_ready, mem_we;
    logic [11:0] mem_addr;
    logic [7:0]  mem_wdata, mem_rdata;
    logic [11:0] cpu_address;
    logic [7:0]  cpu_dbus;
    logic        cpu_reset, busy, err_ovf;

    int passed = 0;
    int total  = 0;

    always #5 clock = ~clock;

    boot_sequencer #(.RST_HOLD(4), .NOP_CODE(8'h00)) dut (
        .clock(clock), .reset(reset),
        .ld_start(ld_start), .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last),
        .ld_ready(ld_ready), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .cpu_address(cpu_address), .cpu_dbus(cpu_dbus),
        .cpu_reset(cpu_reset), .busy(busy), .err_ovf(err_ovf)
    );

    // Unwritten locations read back a fixed pattern: addr[7:0] ^ 8'h5A
    bit [7:0] mem [4096];
    bit       written [4096];

    always @(posedge clock) begin
        if (mem_we) begin
            mem[mem_addr]     <= mem_wdata;
            written[mem_addr] <= 1'b1;
        end
    end

    assign mem_rdata = written[mem_addr] ? mem[mem_addr] : (mem_addr[7:0] ^ 8'h5A);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    typedef struct packed {
        logic        st;
        logic        v;
        logic [7:0]  d;
        logic        l;
        logic [11:0] ca;
        logic        rdy;
        logic        we;
        logic [11:0] ma;
        logic        cr;
        logic        bz;
        logic        ef;
        logic [7:0]  db;
    } vec_t;

    vec_t tv [0:22];

    initial begin
        int cycles;

        //        st    v     d      l     ca        rdy   we    ma        cr    bz    ef    db
        tv[0]  = '{1'b0, 1'b0, 8'h00, 1'b0, 12'h000, 1'b0, 1'b0, 12'h000, 1'b1, 1'b1, 1'b0, 8'h00};
        tv[1]  = tv[0];
        tv[2]  = tv[0];
        tv[3]  = tv[0];
        tv[4]  = '{1'b0, 1'b0, 8'h00, 1'b0, 12'h010, 1'b0, 1'b0, 12'h010, 1'b0, 1'b0, 1'b0, 8'h4A};
        tv[5]  = '{1'b0, 1'b1, 8'h55, 1'b0, 12'hABC, 1'b0, 1'b0, 12'hABC, 1'b0, 1'b0, 1'b0, 8'hE6};
        tv[6]  = '{1'b1, 1'b0, 8'h00, 1'b0, 12'h005, 1'b0, 1'b0, 12'h005, 1'b0, 1'b0, 1'b0, 8'h5F};
        tv[7]  = '{1'b0, 1'b1, 8'hA1, 1'b0, 12'h005, 1'b1, 1'b1, 12'h000, 1'b1, 1'b1, 1'b0, 8'h00};
        tv[8]  = '{1'b0, 1'b0, 8'hFF, 1'b0, 12'h005, 1'b1, 1'b0, 12'h001, 1'b1, 1'b1, 1'b0, 8'h00};
        tv[9]  = '{1'b0, 1'b1, 8'hB2, 1'b0, 12'h005, 1'b1, 1'b1, 12'h001, 1'b1, 1'b1, 1'b0, 8'h00};
        tv[10] = '{1'b0, 1'b1, 8'hC3, 1'b1, 12'h005, 1'b1, 1'b1, 12'h002, 1'b1, 1'b1, 1'b0, 8'h00};
        tv[11] = '{1'b0, 1'b0, 8'h00, 1'b0, 12'h005, 1'b0, 1'b0, 12'h000, 1'b1, 1'b1, 1'b0, 8'h00};
        tv[12] = tv[11];
        tv[13] = tv[11];
        tv[14] = tv[11];
        tv[15] = '{1'b0, 1'b0, 8'h00, 1'b0, 12'h000, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0, 8'hA1};
        tv[16] = '{1'b0, 1'b0, 8'h00, 1'b0, 12'h002, 1'b0, 1'b0, 12'h002, 1'b0, 1'b0, 1'b0, 8'hC3};
        tv[17] = '{1'b1, 1'b0, 8'h00, 1'b0, 12'h001, 1'b0, 1'b0, 12'h001, 1'b0, 1'b0, 1'b0, 8'hB2};
        tv[18] = '{1'b0, 1'b1, 8'hD4, 1'b0, 12'h001, 1'b1, 1'b1, 12'h000, 1'b1, 1'b1, 1'b0, 8'h00};
        tv[19] = '{1'b1, 1'b1, 8'hE5, 1'b1, 12'h001, 1'b1, 1'b1, 12'h001, 1'b1, 1'b1, 1'b0, 8'h00};
        tv[20] = '{1'b0, 1'b0, 8'h00, 1'b0, 12'h001, 1'b1, 1'b0, 12'h000, 1'b1, 1'b1, 1'b0, 8'h00};
        tv[21] = '{1'b0, 1'b1, 8'h77, 1'b1, 12'h001, 1'b1, 1'b1, 12'h000, 1'b1, 1'b1, 1'b0, 8'h00};
        tv[22] = '{1'b0, 1'b0, 8'h00, 1'b0, 12'h001, 1'b0, 1'b0, 12'h000, 1'b1, 1'b1, 1'b0, 8'h00};

        reset = 1'b1;
        ld_start = 1'b0; ld_valid = 1'b0; ld_last = 1'b0; ld_data = 8'h00;
        cpu_address = 12'h123;
        repeat (2) @(negedge clock);
        #1;
        check("rst_cpu_reset", cpu_reset, 1'b1);
        check("rst_busy", busy, 1'b1);
        check("rst_ld_ready", ld_ready, 1'b0);
        check("rst_mem_we", mem_we, 1'b0);
        check("rst_mem_addr", mem_addr, 12'h000);
        check("rst_cpu_dbus", cpu_dbus, 8'h00);
        check("rst_err_ovf", err_ovf, 1'b0);
        @(negedge clock);
        reset = 1'b0;

        for (int i = 0; i <= 22; i++) begin
            ld_start = tv[i].st; ld_valid = tv[i].v; ld_data = tv[i].d;
            ld_last = tv[i].l; cpu_address = tv[i].ca;
            #1;
            check($sformatf("v%0d_ld_ready", i), ld_ready, tv[i].rdy);
            check($sformatf("v%0d_mem_we", i), mem_we, tv[i].we);
            check($sformatf("v%0d_mem_addr", i), mem_addr, tv[i].ma);
            check($sformatf("v%0d_cpu_reset", i), cpu_reset, tv[i].cr);
            check($sformatf("v%0d_busy", i), busy, tv[i].bz);
            check($sformatf("v%0d_err_ovf", i), err_ovf, tv[i].ef);
            check($sformatf("v%0d_cpu_dbus", i), cpu_dbus, tv[i].db);
            if (tv[i].we) check($sformatf("v%0d_mem_wdata", i), mem_wdata, tv[i].d);
            @(negedge clock);
        end
        ld_start = 1'b0; ld_valid = 1'b0; ld_last = 1'b0;
        check("mem0_after_loads", mem[0], 8'h77);
        check("mem1_after_loads", mem[1], 8'hE5);
        check("mem2_after_loads", mem[2], 8'hC3);

        // Overflow: 4097 bytes, last on the final one
        ld_start = 1'b1;
        @(negedge clock);
        ld_start = 1'b0;
        for (int i = 0; i <= 4096; i++) begin
            ld_valid = 1'b1;
            ld_data  = (i == 4096) ? 8'hEE : 8'(i);
            ld_last  = (i == 4096);
            #1;
            if (i == 4095) begin
                check("ovf_addr_4095", mem_addr, 12'hFFF);
                check("ovf_err_before", err_ovf, 1'b0);
            end
            if (i == 4096) begin
                check("ovf_err_after", err_ovf, 1'b1);
                check("ovf_wrap_addr", mem_addr, 12'h000);
                check("ovf_still_load", ld_ready, 1'b1);
                check("ovf_we_last", mem_we, 1'b1);
            end
            @(negedge clock);
        end
        ld_valid = 1'b0; ld_last = 1'b0;
        #1;
        check("ovf_hold_ready", ld_ready, 1'b0);
        check("ovf_hold_busy", busy, 1'b1);
        check("ovf_sticky", err_ovf, 1'b1);
        check("ovf_mem0", mem[0], 8'hEE);
        check("ovf_mem4095", mem[4095], 8'hFF);
        ld_start = 1'b1;
        @(negedge clock);
        ld_start = 1'b0;
        #1;
        check("start_clears_err", err_ovf, 1'b0);
        check("start_enters_load", ld_ready, 1'b1);

        // Reset mid-load at byte 2
        ld_valid = 1'b1; ld_data = 8'h11;
        @(negedge clock);
        ld_data = 8'h22;
        #1;
        check("midload_we_before", mem_we, 1'b1);
        check("midload_addr_before", mem_addr, 12'h001);
        #2;
        reset = 1'b1;
        #1;
        check("midload_we_drop", mem_we, 1'b0);
        check("midload_ready_drop", ld_ready, 1'b0);
        check("midload_cpu_reset", cpu_reset, 1'b1);
        check("midload_busy", busy, 1'b1);
        check("midload_addr", mem_addr, 12'h000);
        @(negedge clock);
        reset = 1'b0; ld_valid = 1'b0;
        cycles = 0;
        for (int k = 0; k < 20; k++) begin
            #1;
            if (!cpu_reset) break;
            cycles++;
            @(negedge clock);
        end
        check("midload_hold_cycles", cycles, 4);
        check("midload_run_busy", busy, 1'b0);
        check("midload_mem0", mem[0], 8'h11);
        check("midload_mem1_untouched", mem[1], 8'h01);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
